// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data memory arbiter
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;
    localparam logic [3:0] LANE_MASK = 4'b1111;
    localparam int DEF_ADDR_W = 10;
endpackage

// File: rtl/round_robin_arb2.sv
// round_robin_arb2: two-way round-robin grant, favouring the port not granted last
module round_robin_arb2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic valid_o,
    output logic grant_o
);
    assign valid_o = req0_i | req1_i;
    assign grant_o = (req0_i & req1_i) ? ~last_grant_i : req1_i;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sequencer splitting misaligned accesses into two word accesses
module data_mem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memWe,
    output logic [3:0]        memBe,
    output logic [31:0]       memWdata,
    input  logic [31:0]       memRdata
);
    state_t state_q, state_d;
    logic last_q, last_d, id_q, id_d, we_q, we_d;
    logic [1:0] off_q, off_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [31:0] wdata_q, wdata_d, lo_q, lo_d, hi_q, hi_d, rdata_q, rdata_d, sel_addr;
    logic [63:0] joined;
    logic arb_valid, arb_id;

    round_robin_arb2 u_arb (
        .req0_i      (req0),
        .req1_i      (req1),
        .last_grant_i(last_q),
        .valid_o     (arb_valid),
        .grant_o     (arb_id)
    );

    assign sel_addr = arb_id ? addr1 : addr0;
    assign joined   = {hi_q, lo_q} >> {off_q, 3'b000};
    assign busy     = state_q != IDLE;
    // a completing load presents its assembled word in the ack cycle itself
    assign rdata    = (state_q == DONE && !we_q) ? joined[31:0] : rdata_q;

    // next-state, request latching and memory-side drive
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        we_d     = we_q;
        off_d    = off_q;
        word_d   = word_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        rdata_d  = rdata_q;
        memAddr  = '0;
        memWe    = 1'b0;
        memBe    = 4'b0;
        memWdata = '0;
        ack0     = 1'b0;
        ack1     = 1'b0;
        unique case (state_q)
            IDLE: if (arb_valid) begin
                state_d = FIRST;
                id_d    = arb_id;
                last_d  = arb_id;
                we_d    = arb_id ? we1 : we0;
                wdata_d = arb_id ? wdata1 : wdata0;
                off_d   = sel_addr[1:0];
                word_d  = sel_addr[ADDR_W+1:2];
            end
            FIRST: begin
                memAddr  = word_q;
                memWe    = we_q;
                memBe    = LANE_MASK << off_q;
                memWdata = wdata_q << {off_q, 3'b000};
                lo_d     = we_q ? lo_q : memRdata;
                hi_d     = '0;
                state_d  = (off_q != 2'd0) ? SECOND : DONE;
            end
            SECOND: begin
                memAddr  = word_q + 1'b1;
                memWe    = we_q;
                memBe    = ~(LANE_MASK << off_q);
                memWdata = wdata_q >> (6'd32 - {off_q, 3'b000});
                hi_d     = we_q ? hi_q : memRdata;
                state_d  = DONE;
            end
            default: begin
                ack0    = ~id_q;
                ack1    = id_q;
                rdata_d = we_q ? rdata_q : joined[31:0];
                state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers; reset favours port 0 on the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            off_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            we_q    <= we_d;
            off_q   <= off_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed self-checking bench with a behavioural data memory
module tb_data_mem_arbiter;
    logic clk = 1'b0, reset = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic ack0, ack1, busy, memWe;
    logic [31:0] rdata, memWdata, memRdata;
    logic [9:0] memAddr;
    logic [3:0] memBe;
    logic [31:0] mem [1024];
    int pass = 0, total = 0;

    data_mem_arbiter #(.ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .memAddr(memAddr), .memWe(memWe), .memBe(memBe), .memWdata(memWdata), .memRdata(memRdata)
    );

    always #5 clk = ~clk;

    assign memRdata = mem[memAddr];

    always @(posedge clk)
        if (memWe)
            for (int i = 0; i < 4; i++)
                if (memBe[i]) mem[memAddr][8*i +: 8] = memWdata[8*i +: 8];

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass++;
        total++; if ({ack0, ack1, memWe, memBe} !== 7'b0) $display("FAIL reset_ctl: got %b want 0", {ack0, ack1, memWe, memBe}); else pass++;
        total++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_aligned_load;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd20;
        tick();
        total++; if (memAddr !== 10'd5) $display("FAIL al_addr: got %0d want 5", memAddr); else pass++;
        total++; if (memBe !== 4'hF) $display("FAIL al_be: got %h want f", memBe); else pass++;
        total++; if ({memWe, ack0, busy} !== 3'b001) $display("FAIL al_first: got %b want 001", {memWe, ack0, busy}); else pass++;
        tick();
        total++; if ({ack0, ack1} !== 2'b10) $display("FAIL al_ack: got %b want 10", {ack0, ack1}); else pass++;
        total++; if (rdata !== 32'hDEADBEEF) $display("FAIL al_rdata: got %h want deadbeef", rdata); else pass++;
        total++; if ({memAddr, memBe} !== 14'h0) $display("FAIL al_done_mem: got %h want 0", {memAddr, memBe}); else pass++;
        req0 = 1'b0;
        tick();
        total++; if ({ack0, busy} !== 2'b00) $display("FAIL al_idle: got %b want 00", {ack0, busy}); else pass++;
        total++; if (rdata !== 32'hDEADBEEF) $display("FAIL al_hold: got %h want deadbeef", rdata); else pass++;
    endtask

    task automatic test_misaligned_store;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd6; wdata1 = 32'h44332211;
        tick();
        total++; if ({memWe, memAddr, memBe} !== {1'b1, 10'd1, 4'b1100}) $display("FAIL ms_first: got %b/%0d/%b want 1/1/1100", memWe, memAddr, memBe); else pass++;
        total++; if (memWdata !== 32'h22110000) $display("FAIL ms_first_wd: got %h want 22110000", memWdata); else pass++;
        tick();
        total++; if ({memWe, memAddr, memBe} !== {1'b1, 10'd2, 4'b0011}) $display("FAIL ms_second: got %b/%0d/%b want 1/2/0011", memWe, memAddr, memBe); else pass++;
        total++; if (memWdata !== 32'h00004433) $display("FAIL ms_second_wd: got %h want 00004433", memWdata); else pass++;
        total++; if ({ack0, ack1} !== 2'b00) $display("FAIL ms_early_ack: got %b want 00", {ack0, ack1}); else pass++;
        tick();
        total++; if ({ack0, ack1, memWe} !== 3'b010) $display("FAIL ms_ack: got %b want 010", {ack0, ack1, memWe}); else pass++;
        total++; if (rdata !== 32'hDEADBEEF) $display("FAIL ms_rdata_kept: got %h want deadbeef", rdata); else pass++;
        req1 = 1'b0; we1 = 1'b0;
        tick();
        total++; if (mem[1] !== 32'h2211AAAA) $display("FAIL ms_word1: got %h want 2211aaaa", mem[1]); else pass++;
        total++; if (mem[2] !== 32'hBBBB4433) $display("FAIL ms_word2: got %h want bbbb4433", mem[2]); else pass++;
    endtask

    task automatic test_misaligned_load;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd6;
        tick();
        total++; if ({memWe, memAddr} !== {1'b0, 10'd1}) $display("FAIL ml_first: got %b/%0d want 0/1", memWe, memAddr); else pass++;
        tick();
        total++; if ({memWe, memAddr} !== {1'b0, 10'd2}) $display("FAIL ml_second: got %b/%0d want 0/2", memWe, memAddr); else pass++;
        tick();
        total++; if ({ack0, ack1} !== 2'b10) $display("FAIL ml_ack: got %b want 10", {ack0, ack1}); else pass++;
        total++; if (rdata !== 32'h44332211) $display("FAIL ml_rdata: got %h want 44332211", rdata); else pass++;
        req0 = 1'b0;
        tick();
    endtask

    task automatic test_wrap;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4095;
        tick();
        total++; if ({memAddr, memBe} !== {10'd1023, 4'b1000}) $display("FAIL wr_first: got %0d/%b want 1023/1000", memAddr, memBe); else pass++;
        tick();
        total++; if ({memAddr, memBe} !== {10'd0, 4'b0111}) $display("FAIL wr_second: got %0d/%b want 0/0111", memAddr, memBe); else pass++;
        tick();
        total++; if ({ack0, ack1} !== 2'b01) $display("FAIL wr_ack: got %b want 01", {ack0, ack1}); else pass++;
        total++; if (rdata !== 32'h66778811) $display("FAIL wr_rdata: got %h want 66778811", rdata); else pass++;
        req1 = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        int n = 0;
        logic both = 1'b0;
        logic [3:0] who = '0;
        logic [31:0] got [4];
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'd0; addr1 = 32'd4;
        for (int c = 0; c < 30 && n < 4; c++) begin
            tick();
            if (ack0 && ack1) both = 1'b1;
            if (ack0 || ack1) begin
                who[n] = ack1;
                got[n] = rdata;
                n++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        total++; if (n !== 4) $display("FAIL bb_count: got %0d acks want 4", n); else pass++;
        total++; if (both !== 1'b0) $display("FAIL bb_dual_ack: got %b want 0", both); else pass++;
        total++; if (who !== 4'b1010) $display("FAIL bb_order: got %b (bit i = port of ack i) want 1010", who); else pass++;
        for (int i = 0; i < n; i++) begin
            total++; if (got[i] !== (i % 2 == 1 ? 32'h2211AAAA : 32'h55667788)) $display("FAIL bb_rdata%0d: got %h want %h", i, got[i], i % 2 == 1 ? 32'h2211AAAA : 32'h55667788); else pass++;
        end
        tick();
    endtask

    task automatic test_reset_mid_op;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd9; wdata0 = 32'hCAFEF00D;
        tick();
        total++; if ({memBe, memWdata} !== {4'b1110, 32'hFEF00D00}) $display("FAIL rm_first: got %b/%h want 1110/fef00d00", memBe, memWdata); else pass++;
        tick();
        total++; if ({memAddr, memBe, memWdata} !== {10'd3, 4'b0001, 32'h000000CA}) $display("FAIL rm_second: got %0d/%b/%h want 3/0001/000000ca", memAddr, memBe, memWdata); else pass++;
        #1 reset = 1'b1;
        #1;
        total++; if ({ack0, ack1, busy, memWe, memBe, memAddr, memWdata} !== 50'h0) $display("FAIL rm_outputs: got %b%b%b%b %b %0d %h want all zero", ack0, ack1, busy, memWe, memBe, memAddr, memWdata); else pass++;
        total++; if (rdata !== 32'h0) $display("FAIL rm_rdata: got %h want 0", rdata); else pass++;
        req0 = 1'b0; we0 = 1'b0;
        tick();
        reset = 1'b0;
        total++; if (mem[2] !== 32'hFEF00D33) $display("FAIL rm_word2: got %h want fef00d33", mem[2]); else pass++;
        total++; if (mem[3] !== 32'h12345678) $display("FAIL rm_word3: got %h want 12345678", mem[3]); else pass++;
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'd0; addr1 = 32'd4;
        tick();
        total++; if (memAddr !== 10'd0) $display("FAIL rm_tie_grant: got word %0d want 0", memAddr); else pass++;
        tick();
        total++; if ({ack0, ack1} !== 2'b10) $display("FAIL rm_tie_ack: got %b want 10", {ack0, ack1}); else pass++;
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[5]    = 32'hDEADBEEF;
        mem[1]    = 32'h5555AAAA;
        mem[2]    = 32'hBBBB6666;
        mem[3]    = 32'h12345678;
        mem[1023] = 32'h11223344;
        mem[0]    = 32'h55667788;
        test_reset();
        test_aligned_load();
        test_misaligned_store();
        test_misaligned_load();
        test_wrap();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Sequencer and arbiter sitting in front of the single-port, word-organised data memory (1024 × 32 bit, combinational read, byte-enabled synchronous write). Two requesters share it: port 0 is the CPU load/store path; port 1 is a secondary master such as a loader or debug port. The block grants one request at a time round-robin. It splits byte-misaligned accesses into two aligned word accesses with byte enables, and returns little-endian assembled read data with a one-cycle ack.

## Interface
Parameters:
- `ADDR_W`, 10: word-index width of the memory (depth = 2^ADDR_W).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0` / `req1`  in  1  request from requester 0 / 1.
- `we0` / `we1`  in  1  1 = store, 0 = load.
- `addr0` / `addr1`  in  32  byte address; only bits [ADDR_W+1:0] are used.
- `wdata0` / `wdata1`  in  32  store data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata`  out  32  load result, valid with ack, held until the next load completes.
- `busy`  out  1  high whenever state ≠ IDLE.
- `memAddr`  out  ADDR_W  word index to memory.
- `memWe`  out  1  memory write strobe.
- `memBe`  out  4  byte enables; bit i covers bits [8i+7:8i].
- `memWdata`  out  32  memory write data.
- `memRdata`  in  32  memory combinational read data.

## Operation
- Byte address A, offset o = A[1:0], word w0 = A[ADDR_W+1:2], w1 = w0+1 mod 2^ADDR_W; index 2^ADDR_W−1 wraps to 0.
- Byte semantics: data byte i ↔ memory byte A+i; memory byte b lives in word b>>2, lane b%4.
- FSM states:
  - IDLE: sample req0/req1. The winner's we/addr/wdata and id are latched; next state is FIRST. No request: stay in IDLE.
  - FIRST: memAddr=w0, memBe=4'b1111<<o (masked to 4 bits). memWdata=wdata<<8o. memWe=we. On a load, capture memRdata into lo. Next state: SECOND if o≠0, else DONE.
  - SECOND: memAddr=w1, memBe=~(4'b1111<<o)&4'hF, memWdata=wdata>>(8·(4−o)), memWe=we. On a load, capture memRdata into hi.
  - DONE: pulse the winner's ack. On a load, rdata ← ({hi,lo}>>8o)[31:0]; hi is treated as 0 when o=0. Next state is IDLE.
- Arbitration: if only one request is present, it wins. If both are present, the requester not granted last time wins. lastGrant resets to 1, so port 0 wins the first tie.
- In IDLE and DONE: memWe=0, memBe=0, memAddr=0, memWdata=0.
- The requester must hold req and its fields stable until ack. Dropping req early is illegal; the latched request still completes.
- A store never modifies rdata.

## Timing
- Request seen in IDLE at cycle 0:
  - aligned access: FIRST at cycle 1, ack at cycle 2;
  - misaligned access: SECOND at cycle 2, ack at cycle 3.
- The cycle after DONE is IDLE. A requester that keeps req high after ack is treated as issuing a new request, sampled in that IDLE cycle. Peak throughput is one aligned access per 3 cycles.
- A request arriving while busy waits; it is sampled in the next IDLE.
- Reset (asynchronous, any state):
  - state → IDLE immediately, lastGrant → 1;
  - ack0=ack1=0, rdata=0, busy=0, all mem* outputs 0;
  - an in-flight misaligned store may leave only its first word written. This is accepted.
- Only one of ack0/ack1 is ever high in a given cycle.

## Structure
- Shared package `dmem_pkg`:
  - FSM state enum (IDLE, FIRST, SECOND, DONE);
  - byte-lane mask constant 4'b1111;
  - default `ADDR_W`.
- One sub-module, `round_robin_arb2`: inputs req0, req1, lastGrant; outputs a valid flag and the grant id. It is combinational. lastGrant is a register in the parent, updated on entry to FIRST.
- All remaining logic stays in the top: FSM, request latches, lo/hi capture registers, lane shifting.

## Test plan
- Aligned load: memory word 5 = 32'hDEADBEEF; req0, we0=0, addr0=20. Expected: ack0 at cycle 2, rdata=32'hDEADBEEF, memBe=4'hF in FIRST.
- Misaligned store: req1, addr1=6, wdata1=32'h44332211. Expected: FIRST word 1, memBe=4'b1100, memWdata=32'h22110000; SECOND word 2, memBe=4'b0011, memWdata=32'h00004433; ack1 at cycle 3.
- Misaligned load readback: word 1=32'h2211AAAA, word 2=32'hBBBB4433, addr=6. Expected: rdata=32'h44332211.
- Wrap: addr=4095 (o=3), load. Expected: FIRST memAddr=1023, SECOND memAddr=0.
- Contention: req0 and req1 both high continuously for 4 transactions. Expected: acks alternate 0,1,0,1; never both high in one cycle.
- Reset mid-operation: assert reset during SECOND of a store. Expected: outputs zero within the same cycle, no ack; next tie after reset is granted to port 0.
